hazard_forward_unit: RTL
========================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter REG_W, default 3, register-address width in bits.
REQ-002 SHALL have parameter ZERO_REG, default 1; when 1, address 0 never forwards and never causes a stall.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width in bits.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port id_valid  input  1  decode-stage instruction is valid.
REQ-007 SHALL have ports id_rs1 and id_rs2, each input, REG_W wide: decode-stage source addresses.
REQ-008 SHALL have port id_rd  input  REG_W  decode-stage destination address.
REQ-009 SHALL have ports id_we, id_ld and id_st, each input, 1 bit: register write, load and store flags.
REQ-010 SHALL have port flush  input  1  squash the decode-stage instruction (branch taken in EX).
REQ-011 SHALL have ports fwd1 and fwd2, each output, 2 bits: EX operand source select (0 = MEM result, 1 = WB result, 2 = register file, 3 = unused).
REQ-012 SHALL have port fwd3  output  1  store-data select for MEM (0 = WB result, 1 = pipeline value).
REQ-013 SHALL have port stall  output  1  hold PC and IF/ID, insert a bubble into EX.
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-015 SHALL hold internal stage registers: EX {valid, rs1, rs2, rd, we, ld, st}, MEM {valid, rs2, rd, we, ld, st}, WB {valid, rd, we}.
REQ-016 SHALL define a producer P as "live" when P.valid = 1 and P.we = 1 and (ZERO_REG = 0 or P.rd != 0).
REQ-017 SHALL drive fwd1 combinationally: 0 if MEM is live and MEM.rd == EX.rs1; else 1 if WB is live and WB.rd == EX.rs1; else 2.
REQ-018 SHALL drive fwd2 by the rule in REQ-017, with EX.rs2 in place of EX.rs1.
REQ-019 SHALL give MEM priority over WB when both match the same source address.
REQ-020 SHALL drive fwd1 = fwd2 = 2 whenever EX.valid = 0.
REQ-021 SHALL drive fwd3 = 0 when MEM.valid = 1, MEM.st = 1, WB is live and WB.rd == MEM.rs2; otherwise fwd3 = 1.
REQ-022 SHALL form the load-use hazard term as: id_valid = 1, EX is live, EX.ld = 1, and (id_rs1 == EX.rd or id_rs2 == EX.rd).
REQ-023 SHALL drive stall combinationally as (load-use hazard term AND NOT flush).
REQ-024 SHALL update stage registers on each edge with no stall and no flush: EX <= ID inputs, MEM <= EX, WB <= MEM.
REQ-025 SHALL update stage registers on an edge with stall = 1: EX.valid <= 0 (bubble), MEM <= EX, WB <= MEM.
REQ-026 SHALL update stage registers on an edge with flush = 1: EX.valid <= 0, MEM <= EX, WB <= MEM; flush overrides any hazard.
REQ-027 SHALL introduce zero-cycle latency from stage registers to fwd1, fwd2, fwd3 and stall (combinational outputs).
REQ-028 SHALL release the stall one cycle after a single load-use hazard, because the load has advanced to MEM and fwd selects 0.
REQ-029 SHALL increment stall_cnt by 1 on every edge with stall = 1, and hold it at 2^CNT_W-1 once reached (no wrap).
REQ-030 SHALL ignore all register contents when the valid bit is 0: no forwarding from, and no stall against, bubbles.

Reset
REQ-031 SHALL, while rst_n = 0 and independent of clk, clear all valid bits, clear all stage fields to 0, and clear stall_cnt to 0.
REQ-032 SHALL present fwd1 = 2, fwd2 = 2, fwd3 = 1 and stall = 0 while in reset, plus stall = 0 for any ID input.
REQ-033 SHALL leave no in-flight state after reset asserted mid-pipeline; the first post-reset cycle behaves as an empty pipeline.

Verification
REQ-034 SHALL cover: add r3 then add r1=r3+r2 back-to-back -> in the consumer EX cycle, fwd1 = 0 and fwd2 = 2; one cycle later, with r3 in WB only, fwd1 = 1.
REQ-035 SHALL cover: ld r4 then add r5=r4+r4 -> stall = 1 for exactly one cycle, EX bubble, then fwd1 = fwd2 = 0, and stall_cnt = 1.
REQ-036 SHALL cover: ZERO_REG = 1 with producer rd = 0 and consumer rs1 = 0 -> fwd1 = 2 and no stall; with ZERO_REG = 0 -> fwd1 = 0.
REQ-037 SHALL cover: MEM.rd == WB.rd == EX.rs2 = 6, both live -> fwd2 = 0 (MEM priority).
REQ-038 SHALL cover: load-use hazard with flush = 1 the same cycle -> stall = 0, EX bubble, stall_cnt unchanged.
REQ-039 SHALL cover: CNT_W = 2 with 5 consecutive stall cycles -> stall_cnt reads 1, 2, 3, 3, 3; rst_n pulsed low mid-stall -> stall_cnt = 0, and fwd1 = fwd2 = 2 immediately.

Source files
------------

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Brief    : Operand-forwarding select and load-use stall generation for a
//            five-stage in-order pipeline. Tracks the EX, MEM and WB stages
//            internally and counts stall cycles with a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
  parameter int REG_W    = 3,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_ld,
  input  logic             id_st,
  input  logic             flush,
  output logic [1:0]       fwd1,
  output logic [1:0]       fwd2,
  output logic             fwd3,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  // Operand source encodings for fwd1/fwd2
  localparam logic [1:0] C_SEL_MEM = 2'd0;
  localparam logic [1:0] C_SEL_WB  = 2'd1;
  localparam logic [1:0] C_SEL_RF  = 2'd2;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // EX stage
  logic             r_ex_valid, r_ex_we, r_ex_ld, r_ex_st;
  logic [REG_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
  // MEM stage (ld is carried for completeness of the stage record)
  logic             r_mem_valid, r_mem_we, r_mem_ld, r_mem_st;
  logic [REG_W-1:0] r_mem_rs2, r_mem_rd;
  // WB stage
  logic             r_wb_valid, r_wb_we;
  logic [REG_W-1:0] r_wb_rd;

  logic w_ex_live, w_mem_live, w_wb_live;
  logic w_load_use;

  // A producer only matters when it is a real, writing instruction; with
  // ZERO_REG set, writes to address 0 are discarded and so never forward.
  assign w_ex_live  = r_ex_valid  && r_ex_we  && ((ZERO_REG == 0) || (r_ex_rd  != '0));
  assign w_mem_live = r_mem_valid && r_mem_we && ((ZERO_REG == 0) || (r_mem_rd != '0));
  assign w_wb_live  = r_wb_valid  && r_wb_we  && ((ZERO_REG == 0) || (r_wb_rd  != '0));

  assign w_load_use = id_valid && w_ex_live && r_ex_ld &&
                      ((id_rs1 == r_ex_rd) || (id_rs2 == r_ex_rd));

  // Forwarding selects and stall; MEM is checked first so the youngest value wins
  always_comb begin
    fwd1  = C_SEL_RF;
    fwd2  = C_SEL_RF;
    fwd3  = 1'b1;
    stall = w_load_use && !flush;
    if (r_ex_valid) begin
      if (w_mem_live && (r_mem_rd == r_ex_rs1))     fwd1 = C_SEL_MEM;
      else if (w_wb_live && (r_wb_rd == r_ex_rs1))  fwd1 = C_SEL_WB;
      if (w_mem_live && (r_mem_rd == r_ex_rs2))     fwd2 = C_SEL_MEM;
      else if (w_wb_live && (r_wb_rd == r_ex_rs2))  fwd2 = C_SEL_WB;
    end
    if (r_mem_valid && r_mem_st && w_wb_live && (r_wb_rd == r_mem_rs2))
      fwd3 = 1'b0;
  end

  // Stage advance: stall or flush turns the incoming EX slot into a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_rs1    <= '0;
      r_ex_rs2    <= '0;
      r_ex_rd     <= '0;
      r_ex_we     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_ex_st     <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rs2   <= '0;
      r_mem_rd    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_ld    <= 1'b0;
      r_mem_st    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_we     <= 1'b0;
    end else begin
      if (stall || flush) begin
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_valid <= id_valid;
        r_ex_rs1   <= id_rs1;
        r_ex_rs2   <= id_rs2;
        r_ex_rd    <= id_rd;
        r_ex_we    <= id_we;
        r_ex_ld    <= id_ld;
        r_ex_st    <= id_st;
      end
      r_mem_valid <= r_ex_valid;
      r_mem_rs2   <= r_ex_rs2;
      r_mem_rd    <= r_ex_rd;
      r_mem_we    <= r_ex_we;
      r_mem_ld    <= r_ex_ld;
      r_mem_st    <= r_ex_st;
      r_wb_valid  <= r_mem_valid;
      r_wb_rd     <= r_mem_rd;
      r_wb_we     <= r_mem_we;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != C_CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
